// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control sequencer: Moore FSM that steps fetch/decode/execute/memory/writeback.
// Latency (MemReady=1): R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2 clocks.
// Backpressure: MemReady=0 holds FETCH/MEMRD/MEMWR with requests stable, one extra cycle per wait.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] Alu_op,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       InstrDone,
    output logic       Illegal
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } stateT;

    stateT state;
    stateT nextState;

    // The branch decision is made by the datapath (PCWriteCond AND Zero), so
    // the sequencer itself never looks at the flag.
    logic unusedZero;
    assign unusedZero = Zero;

    assign State = state;

    // State register with synchronous active-low reset; reset abandons any partial instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and Moore outputs; MemReady only gates FETCH and MEMWR strobes.
    always_comb begin
        nextState   = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = 2'd0;
        Alu_op      = 2'd0;
        PCSource    = 2'd0;
        InstrDone   = 1'b0;
        Illegal     = 1'b0;
        case (state)
            FETCH: begin
                MemRead   = 1'b1;
                AluSrcB   = 2'd1;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                nextState = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                AluSrcB = 2'd3;
                case (Opcode)
                    OpRtype:   nextState = EXEC;
                    OpLw, OpSw: nextState = MEMADR;
                    OpBeq:     nextState = BRANCH;
                    OpJ:       nextState = JUMP;
                    OpAddi:    nextState = ADDIEX;
                    default: begin
                        Illegal   = 1'b1;
                        nextState = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'd2;
                if (Opcode == OpLw) begin
                    nextState = MEMRD;
                end else if (Opcode == OpSw) begin
                    nextState = MEMWR;
                end
            end
            MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                nextState = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = MemReady;
                nextState = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                AluSrcA   = 1'b1;
                Alu_op    = 2'd2;
                nextState = RWB;
            end
            RWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                InstrDone = 1'b1;
            end
            BRANCH: begin
                AluSrcA     = 1'b1;
                Alu_op      = 2'd1;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                InstrDone   = 1'b1;
            end
            JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'd2;
                InstrDone = 1'b1;
            end
            ADDIEX: begin
                AluSrcA   = 1'b1;
                AluSrcB   = 2'd2;
                nextState = ADDIWB;
            end
            ADDIWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            default: nextState = FETCH;
        endcase
        // While reset is held, nothing is strobed and selects rest at 0.
        if (!rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            AluSrcA     = 1'b0;
            AluSrcB     = 2'd0;
            Alu_op      = 2'd0;
            PCSource    = 2'd0;
            InstrDone   = 1'b0;
            Illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed testbench for mips_multicycle_control.
// Each scenario walks an instruction cycle by cycle, checking State and every output.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_mips_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, AluSrcA, InstrDone, Illegal;
    logic [1:0] AluSrcB, Alu_op, PCSource;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    mips_multicycle_control dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .Alu_op(Alu_op),
        .PCSource(PCSource), .State(State), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] outs;
    logic [7:0]  strobes;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, AluSrcA, AluSrcB, Alu_op, PCSource, InstrDone, Illegal};
    assign strobes = {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite,
                      InstrDone, Illegal};

    // Expected output vector for a state, written from the per-state output table.
    function automatic logic [18:0] expOut(input int s, input logic rdy, input logic [5:0] op);
        logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, done, ill;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, done, ill} = '0;
        asb = 2'd0; aop = 2'd0; psrc = 2'd0;
        case (s)
            0:  begin mr = 1; asb = 2'd1; irw = rdy; pw = rdy; end
            1:  begin asb = 2'd3;
                      ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                              op == 6'b000100 || op == 6'b000010 || op == 6'b001000); end
            2:  begin asa = 1; asb = 2'd2; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mw = 1; iord = 1; done = rdy; end
            6:  begin asa = 1; aop = 2'd2; end
            7:  begin rw = 1; rd = 1; done = 1; end
            8:  begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; done = 1; end
            9:  begin pw = 1; psrc = 2'd2; done = 1; end
            10: begin asa = 1; asb = 2'd2; end
            11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, done, ill};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; MemReady = 1'b1; Opcode = 6'b100011; Zero = 1'b0;
        tick();
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", State); end
        checks++;
        if (strobes !== 8'h00) begin errors++; $display("FAIL reset_strobes got=%b exp=00000000", strobes); end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== expOut(0, 1'b1, Opcode)) begin errors++; $display("FAIL reset_first_fetch got=%h exp=%h", outs, expOut(0, 1'b1, Opcode)); end
        // Walk lw into MEMRD, stall there, then reset mid-wait.
        tick(); tick(); tick();
        MemReady = 1'b0;
        #1;
        checks++;
        if (State !== 4'd3 || MemRead !== 1'b1) begin errors++; $display("FAIL reset_reach_memrd got=%0d/%b exp=3/1", State, MemRead); end
        rst = 1'b0;
        #1;
        checks++;
        if (strobes !== 8'h00) begin errors++; $display("FAIL reset_midlw_strobes got=%b exp=00000000", strobes); end
        tick();
        checks++;
        if (State !== 4'd0 || strobes !== 8'h00) begin errors++; $display("FAIL reset_midlw_state got=%0d/%b exp=0/00000000", State, strobes); end
        rst = 1'b1; MemReady = 1'b1;
        #1;
        checks++;
        if (MemRead !== 1'b1 || AluSrcB !== 2'd1) begin errors++; $display("FAIL reset_release got=%b/%0d exp=1/1", MemRead, AluSrcB); end
    endtask

    task automatic test_rtype();
        int st [0:4];
        int dones;
        st = '{0, 1, 6, 7, 0};
        dones = 0;
        Opcode = 6'b000000; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (State !== st[i][3:0] || outs !== expOut(st[i], 1'b1, Opcode)) begin
                errors++; $display("FAIL rtype_cycle%0d got=%0d/%h exp=%0d/%h", i, State, outs, st[i], expOut(st[i], 1'b1, Opcode));
            end
            if (i < 4) dones += InstrDone;
            if (i == 3) begin
                checks++;
                if ({RegWrite, RegDst, InstrDone} !== 3'b111) begin errors++; $display("FAIL rtype_rwb got=%b exp=111", {RegWrite, RegDst, InstrDone}); end
            end
            if (i < 4) tick();
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL rtype_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_lw_waits();
        int   st [0:8];
        logic rd [0:8];
        st = '{0, 0, 1, 2, 3, 3, 3, 4, 0};
        rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        Opcode = 6'b100011;
        for (int i = 0; i < 9; i++) begin
            MemReady = rd[i];
            #1;
            checks++;
            if (State !== st[i][3:0] || outs !== expOut(st[i], rd[i], Opcode)) begin
                errors++; $display("FAIL lw_cycle%0d got=%0d/%h exp=%0d/%h", i, State, outs, st[i], expOut(st[i], rd[i], Opcode));
            end
            if (i < 2) begin
                checks++;
                if (IRWrite !== (i == 1)) begin errors++; $display("FAIL lw_irwrite%0d got=%b exp=%b", i, IRWrite, i == 1); end
            end
            if (i == 7) begin
                checks++;
                if (MemtoReg !== 1'b1) begin errors++; $display("FAIL lw_memtoreg got=%b exp=1", MemtoReg); end
            end
            if (i < 8) tick();
        end
        MemReady = 1'b1;
    endtask

    task automatic test_beq();
        int st [0:3];
        st = '{0, 1, 8, 0};
        Opcode = 6'b000100; MemReady = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            Zero = z[0];
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (State !== st[i][3:0] || outs !== expOut(st[i], 1'b1, Opcode)) begin
                    errors++; $display("FAIL beq_z%0d_cycle%0d got=%0d/%h exp=%0d/%h", z, i, State, outs, st[i], expOut(st[i], 1'b1, Opcode));
                end
                if (i == 2) begin
                    checks++;
                    if ({PCWriteCond, PCSource, Alu_op} !== 5'b1_01_01) begin errors++; $display("FAIL beq_z%0d_strobes got=%b exp=10101", z, {PCWriteCond, PCSource, Alu_op}); end
                end
                if (i < 3) tick();
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_sw_j();
        int   st [0:5];
        logic rd [0:5];
        int   sj [0:3];
        st = '{0, 1, 2, 5, 5, 0};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        sj = '{0, 1, 9, 0};
        Opcode = 6'b101011;
        for (int i = 0; i < 6; i++) begin
            MemReady = rd[i];
            #1;
            checks++;
            if (State !== st[i][3:0] || outs !== expOut(st[i], rd[i], Opcode)) begin
                errors++; $display("FAIL sw_cycle%0d got=%0d/%h exp=%0d/%h", i, State, outs, st[i], expOut(st[i], rd[i], Opcode));
            end
            if (i == 3 || i == 4) begin
                checks++;
                if ({MemWrite, IorD, InstrDone} !== {2'b11, rd[i]}) begin errors++; $display("FAIL sw_memwr%0d got=%b exp=%b", i, {MemWrite, IorD, InstrDone}, {2'b11, rd[i]}); end
            end
            if (i < 5) tick();
        end
        Opcode = 6'b000010; MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (State !== sj[i][3:0] || outs !== expOut(sj[i], 1'b1, Opcode)) begin
                errors++; $display("FAIL j_cycle%0d got=%0d/%h exp=%0d/%h", i, State, outs, sj[i], expOut(sj[i], 1'b1, Opcode));
            end
            if (i == 2) begin
                checks++;
                if ({PCWrite, PCSource} !== 3'b1_10) begin errors++; $display("FAIL j_jump got=%b exp=110", {PCWrite, PCSource}); end
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_addi_back_to_back();
        int st [0:4];
        st = '{0, 1, 10, 11, 0};
        Opcode = 6'b001000; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (State !== st[i][3:0] || outs !== expOut(st[i], 1'b1, Opcode)) begin
                errors++; $display("FAIL addi_cycle%0d got=%0d/%h exp=%0d/%h", i, State, outs, st[i], expOut(st[i], 1'b1, 6'b001000));
            end
            // Opcode changes outside DECODE/MEMADR must not disturb the sequence.
            if (i == 2) Opcode = 6'b111111;
            if (i < 4) tick();
        end
    endtask

    task automatic test_illegal();
        int st [0:2];
        int bad;
        st = '{0, 1, 0};
        bad = 0;
        Opcode = 6'b111111; MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (State !== st[i][3:0] || Illegal !== (i == 1)) begin
                errors++; $display("FAIL illegal_cycle%0d got=%0d/%b exp=%0d/%b", i, State, Illegal, st[i], i == 1);
            end
            if (i < 2) bad += RegWrite + MemWrite + InstrDone;
            if (i < 2) tick();
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL illegal_side_effects got=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_waits();
        test_beq();
        test_sw_j();
        test_addi_back_to_back();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
